// File: rtl/lfsr_prbs_gen_pkg.sv
// Shared constants for the LFSR/PRBS generator: configuration and style names,
// plus the standard PRBS feedback polynomials (x^N term implicit).
package lfsr_prbs_gen_pkg;

    localparam string CFG_FIBONACCI   = "FIBONACCI";
    localparam string CFG_GALOIS      = "GALOIS";

    localparam string STYLE_LOOP      = "LOOP";
    localparam string STYLE_REDUCTION = "REDUCTION";
    localparam string STYLE_AUTO      = "AUTO";

    localparam logic [6:0]  PRBS7_POLY  = 7'h41;
    localparam logic [8:0]  PRBS9_POLY  = 9'h021;
    localparam logic [14:0] PRBS15_POLY = 15'h6001;
    localparam logic [22:0] PRBS23_POLY = 23'h040001;
    localparam logic [30:0] PRBS31_POLY = 31'h10000001;

endpackage

// File: rtl/lfsr_prbs_gen_if.sv
// Word-stream port of the PRBS generator: an advance strobe in, the registered word out.
interface lfsr_prbs_gen_if
    import lfsr_prbs_gen_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 8
);
    logic                    enable;
    logic [OUTPUT_WIDTH-1:0] data_out;

    modport master (output enable, input  data_out);
    modport slave  (input  enable, output data_out);
endinterface

// File: rtl/lfsr_prbs_gen_core.sv
// Combinational multi-step LFSR: every next-state and output bit is a fixed XOR
// of {data_in, state_in}, with the selecting masks worked out at elaboration.
module lfsr_core
    import lfsr_prbs_gen_pkg::*;
#(
    parameter int                    LFSR_WIDTH = 9,
    parameter logic [LFSR_WIDTH-1:0] POLY       = 9'h021,
    parameter string                 CONFIG     = CFG_FIBONACCI,
    parameter int                    DATA_WIDTH = 8,
    parameter string                 STYLE      = STYLE_AUTO
) (
    input  logic [LFSR_WIDTH-1:0] state_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [LFSR_WIDTH-1:0] state_out,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int W = LFSR_WIDTH;
    localparam int D = DATA_WIDTH;
    localparam int N = W + D;

    typedef logic [N-1:0] mask_t;

    if (CONFIG != CFG_FIBONACCI && CONFIG != CFG_GALOIS) begin : g_bad_config
        $error("lfsr_core: LFSR_CONFIG must be FIBONACCI or GALOIS");
    end
    if (STYLE != STYLE_LOOP && STYLE != STYLE_REDUCTION && STYLE != STYLE_AUTO) begin : g_bad_style
        $error("lfsr_core: STYLE must be LOOP, REDUCTION or AUTO");
    end

    // Symbolic run of D single steps: each tracked bit is the set of inputs it XORs.
    // Input index i < W is state_in[i]; index W+j is data_in[j]. The step-k data bit
    // pairs with data_in[D-1-k] so the first generated bit lands in the MSB.
    function automatic mask_t calc_mask(input int idx);
        logic [W-1:0][N-1:0] st;
        logic [D-1:0][N-1:0] dt;
        mask_t               fb;
        st = '0;
        dt = '0;
        for (int i = 0; i < W; i++) st[i][i] = 1'b1;
        for (int k = 0; k < D; k++) begin
            fb = st[W-1];
            fb[N-1-k] = fb[N-1-k] ^ 1'b1;
            if (CONFIG == CFG_GALOIS) begin
                for (int j = W - 1; j > 0; j--)
                    st[j] = st[j-1] ^ (POLY[j] ? fb : mask_t'(0));
                st[0] = fb;
            end else begin
                for (int j = 1; j < W; j++)
                    if (POLY[j]) fb = fb ^ st[j-1];
                st = {st[W-2:0], fb};
            end
            dt[D-1-k] = fb;
        end
        if (idx < W) return st[idx];
        else         return dt[idx-W];
    endfunction

    logic [N-1:0] vec;
    logic [N-1:0] res;

    assign vec = {data_in, state_in};

    for (genvar n = 0; n < N; n++) begin : g_out
        localparam mask_t MASK = calc_mask(n);
        if (STYLE == STYLE_LOOP) begin : g_loop
            logic acc;
            always_comb begin
                acc = 1'b0;
                for (int i = 0; i < N; i++)
                    if (MASK[i]) acc = acc ^ vec[i];
            end
            assign res[n] = acc;
        end else begin : g_red
            assign res[n] = ^(vec & MASK);
        end
    end

    assign state_out = res[W-1:0];
    assign data_out  = res[N-1:W];

endmodule

// File: rtl/lfsr_prbs_gen.sv
// PRBS generator: advances OUTPUT_WIDTH LFSR steps per enabled clock and registers
// the generated bits as one parallel word.
module lfsr_prbs_gen
    import lfsr_prbs_gen_pkg::*;
#(
    parameter int                    LFSR_WIDTH   = 9,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 9'h021,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT    = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG  = CFG_FIBONACCI,
    parameter bit                    REVERSE      = 1'b0,
    parameter int                    OUTPUT_WIDTH = 8,
    parameter string                 STYLE        = STYLE_AUTO
) (
    input  logic              clk,
    input  logic              rst,
    lfsr_prbs_gen_if.slave    bus
);
    if (LFSR_WIDTH < 2 || LFSR_WIDTH > 64) begin : g_bad_width
        $error("lfsr_prbs_gen: LFSR_WIDTH must be 2..64");
    end
    if (OUTPUT_WIDTH < 1 || OUTPUT_WIDTH > LFSR_WIDTH * 8) begin : g_bad_out
        $error("lfsr_prbs_gen: OUTPUT_WIDTH must be 1..LFSR_WIDTH*8");
    end
    if (LFSR_INIT == '0) begin : g_bad_init
        $error("lfsr_prbs_gen: LFSR_INIT must be nonzero (all-zero state locks up)");
    end

    logic [LFSR_WIDTH-1:0]   state_reg;
    logic [LFSR_WIDTH-1:0]   state_next;
    logic [OUTPUT_WIDTH-1:0] word_core;
    logic [OUTPUT_WIDTH-1:0] word_next;
    logic [OUTPUT_WIDTH-1:0] data_reg;

    lfsr_core #(
        .LFSR_WIDTH (LFSR_WIDTH),
        .POLY       (LFSR_POLY),
        .CONFIG     (LFSR_CONFIG),
        .DATA_WIDTH (OUTPUT_WIDTH),
        .STYLE      (STYLE)
    ) u_core (
        .state_in  (state_reg),
        .data_in   ('0),
        .state_out (state_next),
        .data_out  (word_core)
    );

    // Reversed packing puts the first generated bit in the LSB.
    if (REVERSE) begin : g_rev
        for (genvar i = 0; i < OUTPUT_WIDTH; i++) begin : g_bit
            assign word_next[i] = word_core[OUTPUT_WIDTH-1-i];
        end
    end else begin : g_fwd
        assign word_next = word_core;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= LFSR_INIT;
            data_reg  <= '0;
        end else if (bus.enable) begin
            state_reg <= state_next;
            data_reg  <= word_next;
        end
    end

    assign bus.data_out = data_reg;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Scoreboard bench for lfsr_prbs_gen: four configurations share clk/rst/enable and
// are checked against bit-level recurrence models of the PRBS stream.
module tb_lfsr_prbs_gen;
    import lfsr_prbs_gen_pkg::*;

    typedef struct packed {
        logic [63:0] w0;
        logic [63:0] w1;
        logic [63:0] w2;
        logic [63:0] w3;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    lfsr_prbs_gen_if #(.OUTPUT_WIDTH(8))  bus0 ();
    lfsr_prbs_gen_if #(.OUTPUT_WIDTH(8))  bus1 ();
    lfsr_prbs_gen_if #(.OUTPUT_WIDTH(8))  bus2 ();
    lfsr_prbs_gen_if #(.OUTPUT_WIDTH(20)) bus3 ();
    assign bus0.enable = enable;
    assign bus1.enable = enable;
    assign bus2.enable = enable;
    assign bus3.enable = enable;

    lfsr_prbs_gen dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lfsr_prbs_gen #(.REVERSE(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    lfsr_prbs_gen #(.LFSR_CONFIG("GALOIS"), .STYLE("LOOP")) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    lfsr_prbs_gen #(.LFSR_WIDTH(7), .LFSR_POLY(PRBS7_POLY), .OUTPUT_WIDTH(20), .STYLE("REDUCTION"))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int errors = 0;
    int checks = 0;

    exp_t        exp_q[$];
    logic [7:0]  cap_q[$];
    bit          capture = 1'b0;
    bit          h9[$];
    bit          h7[$];
    logic [8:0]  gs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Fibonacci stream as a recurrence on past output bits:
    // x[n] = x[n-W] ^ XOR over set POLY bits j of x[n-j]. h holds the last W bits, oldest first.
    function automatic bit fib_bit(input int w, input logic [63:0] poly, input bit h[$]);
        int n;
        bit b;
        n = h.size();
        b = h[n-w];
        for (int j = 1; j < w; j++)
            if (poly[j]) b = b ^ h[n-j];
        return b;
    endfunction

    task automatic model_reset();
        h9 = {};
        h7 = {};
        repeat (9) h9.push_back(1'b1);
        repeat (7) h7.push_back(1'b1);
        gs = 9'h1FF;
    endtask

    task automatic push_word();
        exp_t       e;
        logic [7:0]  a, r, g;
        logic [19:0] p;
        bit          b;
        a = '0; r = '0; g = '0; p = '0;
        for (int i = 0; i < 8; i++) begin
            b = fib_bit(9, 64'h021, h9);
            h9.push_back(b);
            void'(h9.pop_front());
            a = {a[6:0], b};
            r = {b, r[7:1]};
        end
        for (int i = 0; i < 8; i++) begin
            b  = gs[8];
            gs = {gs[7:0], 1'b0} ^ (b ? (9'h021 & ~9'h001) : 9'h000);
            gs[0] = b;
            g  = {g[6:0], b};
        end
        for (int i = 0; i < 20; i++) begin
            b = fib_bit(7, 64'h41, h7);
            h7.push_back(b);
            void'(h7.pop_front());
            p = {p[18:0], b};
        end
        e.w0 = 64'(a); e.w1 = 64'(r); e.w2 = 64'(g); e.w3 = 64'(p);
        exp_q.push_back(e);
    endtask

    // Called at posedge+2; drives one cycle's enable and returns at the next posedge+2.
    task automatic cycle(input bit en);
        enable = en;
        if (en) push_word();
        @(posedge clk);
        #2;
    endtask

    task automatic async_reset();
        enable = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_dut0", 64'(bus0.data_out), 64'h0);
        chk("async_rst_dut2", 64'(bus2.data_out), 64'h0);
        chk("async_rst_dut3", 64'(bus3.data_out), 64'h0);
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Monitor: one scoreboard entry per enabled edge, otherwise the word must hold.
    initial begin
        logic [63:0] last0, last1, last2, last3;
        bit          en_s, rst_s;
        exp_t        e;
        last0 = '0; last1 = '0; last2 = '0; last3 = '0;
        forever begin
            @(posedge clk);
            en_s  = enable;
            rst_s = rst;
            @(negedge clk);
            if (rst) begin
                last0 = '0; last1 = '0; last2 = '0; last3 = '0;
            end else if (en_s && !rst_s) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: word with no expectation at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    last0 = e.w0; last1 = e.w1; last2 = e.w2; last3 = e.w3;
                    if (capture) cap_q.push_back(bus0.data_out);
                end
            end
            chk("word_fib",     64'(bus0.data_out), last0);
            chk("word_reverse", 64'(bus1.data_out), last1);
            chk("word_galois",  64'(bus2.data_out), last2);
            chk("word_prbs7x20", 64'(bus3.data_out), last3);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit bits[$];
        bit seen[512];
        int per_err, bad_win, v;

        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_dut0", 64'(bus0.data_out), 64'h0);
        chk("reset_dut3", 64'(bus3.data_out), 64'h0);
        rst = 1'b0;

        // Idle after reset: output holds zero.
        repeat (5) cycle(1'b0);
        chk("idle_hold", 64'(bus0.data_out), 64'h0);

        // First words of the default PRBS9 stream, both packings.
        cycle(1'b1);
        chk("first_word",     64'(bus0.data_out), 64'h07);
        chk("first_word_rev", 64'(bus1.data_out), 64'hE0);
        cycle(1'b1);
        chk("second_word",     64'(bus0.data_out), 64'hBE);
        chk("second_word_rev", 64'(bus1.data_out), 64'h7D);
        cycle(1'b0);

        // Mid-stream async reset restarts the sequence.
        async_reset();
        cycle(1'b1);
        chk("restart_word", 64'(bus0.data_out), 64'h07);

        // Alternating enable: same words, held through idle cycles.
        async_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1);
            if (i == 0) chk("toggle_w0", 64'(bus0.data_out), 64'h07);
            if (i == 1) chk("toggle_w1", 64'(bus0.data_out), 64'hBE);
            cycle(1'b0);
            if (i == 1) chk("toggle_hold", 64'(bus0.data_out), 64'hBE);
        end

        // Full-period run: 511 words = 8 periods of the 511-bit PRBS9 sequence.
        async_reset();
        capture = 1'b1;
        repeat (511) cycle(1'b1);
        cycle(1'b0);
        capture = 1'b0;
        chk("capture_len", 64'(cap_q.size()), 64'd511);
        foreach (cap_q[i])
            for (int b = 7; b >= 0; b--) bits.push_back(cap_q[i][b]);
        per_err = 0;
        for (int i = 0; i + 511 < bits.size(); i++)
            if (bits[i] != bits[i+511]) per_err++;
        chk("period_511", 64'(per_err), 64'd0);
        bad_win = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        for (int p = 0; p < 511 && p + 9 <= bits.size(); p++) begin
            v = 0;
            for (int k = 0; k < 9; k++) v = (v << 1) | int'(bits[p+k]);
            if (v == 0 || seen[v]) bad_win++;
            seen[v] = 1'b1;
        end
        chk("windows_unique", 64'(bad_win), 64'd0);

        // Random enable pattern with random mid-stream resets.
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(20, 80)) cycle(1'($urandom_range(0, 1)));
            async_reset();
            cycle(1'b1);
            chk("rand_restart", 64'(bus0.data_out), 64'h07);
        end
        repeat (150) cycle(1'($urandom_range(0, 1)));
        cycle(1'b0);
        @(negedge clk);
        #1;
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
